// File: rtl/wb_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_master_pkg
// Description : Shared types, default widths and helpers for wb_cmd_master.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int DEF_ADR_W   = 32;
    localparam int DEF_DAT_W   = 32;
    localparam int DEF_TIMEOUT = 255;

    // Counter must hold TIMEOUT itself; a disabled timeout still needs one bit.
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int CNT_W = cnt_width(DEF_TIMEOUT);

endpackage
`default_nettype wire

// File: rtl/wb_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : wb_timeout_cnt
// Description : Saturating bus-cycle counter flagging the final timeout cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_timeout_cnt
    import wb_master_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W_P = cnt_width(TIMEOUT)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic expired_o
);

    localparam logic [CNT_W_P-1:0] C_MAX = CNT_W_P'(TIMEOUT);

    logic [CNT_W_P-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != C_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign expired_o = 1'b0;
        end else begin : g_timeout
            // Asserted during the TIMEOUT-th bus cycle, so abort lands on its closing edge.
            assign expired_o = (cnt_q == (C_MAX - 1'b1));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : wb_cmd_master
// Description : Wishbone classic initiator turning a command stream into
//               single read/write cycles with one response per command.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_cmd_master
    import wb_master_pkg::*;
#(
    parameter int ADR_W   = DEF_ADR_W,
    parameter int DAT_W   = DEF_DAT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_we,
    input  logic [ADR_W-1:0]   cmd_adr,
    input  logic [DAT_W-1:0]   cmd_dat,
    input  logic [DAT_W/8-1:0] cmd_sel,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DAT_W-1:0]   rsp_dat,
    output logic               rsp_err,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic               wbm_we_o,
    output logic [ADR_W-1:0]   wbm_adr_o,
    output logic [DAT_W-1:0]   wbm_dat_o,
    output logic [DAT_W/8-1:0] wbm_sel_o,
    input  logic [DAT_W-1:0]   wbm_dat_i,
    input  logic               wbm_ack_i
);

    localparam int SEL_W = DAT_W / 8;

    state_e             state_q, state_d;
    logic               cyc_q, cyc_d;
    logic               stb_q, stb_d;
    logic               we_q, we_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [DAT_W-1:0]   dat_q, dat_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DAT_W-1:0]   rsp_dat_q, rsp_dat_d;
    logic               rsp_err_q, rsp_err_d;

    logic               expired;
    logic               cnt_en;
    logic               cnt_clr;

    assign cnt_en  = (state_q == BUS);
    assign cnt_clr = (state_q == RESP) && rsp_ready;

    wb_timeout_cnt #(
        .TIMEOUT   (TIMEOUT)
    ) u_timeout_cnt (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .en_i      (cnt_en),
        .clr_i     (cnt_clr),
        .expired_o (expired)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid)              state_d = BUS;
            BUS:     if (wbm_ack_i || expired)   state_d = RESP;
            RESP:    if (rsp_ready)              state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    always_comb begin
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    we_d  = cmd_we;
                    adr_d = cmd_adr;
                    dat_d = cmd_dat;
                    sel_d = cmd_sel;
                end
            end
            BUS: begin
                // Ack takes priority over a timeout on the same edge.
                if (wbm_ack_i || expired) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    adr_d       = '0;
                    sel_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !wbm_ack_i;
                    rsp_dat_d   = (wbm_ack_i && !we_q) ? wbm_dat_i : '0;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_cmd_master
// Description : Directed self-checking bench for wb_cmd_master (TIMEOUT = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        cyc, stb, we_o;
    logic [31:0] adr_o, dat_o;
    logic [3:0]  sel_o;
    logic [31:0] sdat = '0;
    logic        ack = 1'b0;

    int n_total = 0;
    int n_bad   = 0;
    int ncyc;

    wb_cmd_master #(
        .ADR_W     (32),
        .DAT_W     (32),
        .TIMEOUT   (8)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (cyc),
        .wbm_stb_o (stb),
        .wbm_we_o  (we_o),
        .wbm_adr_o (adr_o),
        .wbm_dat_o (dat_o),
        .wbm_sel_o (sel_o),
        .wbm_dat_i (sdat),
        .wbm_ack_i (ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a command in IDLE; returns at the negedge of the first bus cycle.
    task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s; cmd_valid = 1'b1;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_we = ~w; cmd_adr = '1; cmd_dat = '1; cmd_sel = '0;
        chk("cyc_bus1", 32'(cyc), 32'd1);
        chk("stb_bus1", 32'(stb), 32'd1);
        chk("we_bus1", 32'(we_o), 32'(w));
        chk("adr_bus1", adr_o, a);
        chk("dat_bus1", dat_o, d);
        chk("sel_bus1", 32'(sel_o), 32'(s));
        chk("cmd_ready_bus", 32'(cmd_ready), 32'd0);
    endtask

    // Ack in bus cycle ack_at (0 = never); counts cycles with cyc high.
    task automatic bus_txn(input int ack_at, input logic [31:0] rd, output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            if (!cyc) break;
            n++;
            ack  = (i == ack_at);
            sdat = (i == ack_at) ? rd : 32'hBAD0_0000 + 32'(i);
            @(negedge clk);
        end
        ack = 1'b0;
    endtask

    task automatic rsp_take(input logic e, input logic [31:0] d);
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_err", 32'(rsp_err), 32'(e));
        chk("rsp_dat", rsp_dat, d);
        chk("cyc_resp", 32'(cyc), 32'd0);
        chk("stb_resp", 32'(stb), 32'd0);
        chk("idle_bus", {adr_o[30:0], we_o}, 32'd0);
        chk("idle_sel", 32'(sel_o), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_clr", 32'(rsp_valid), 32'd0);
        chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // 1. reset
        repeat (3) @(negedge clk);
        chk("rst_cyc", 32'(cyc), 32'd0);
        chk("rst_stb", 32'(stb), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_outs", adr_o | dat_o | rsp_dat | 32'({we_o, sel_o, rsp_err}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // 2. write, ack in second bus cycle
        do_cmd(1'b1, 32'h3000_0000, 32'h0000_00A5, 4'hF);
        bus_txn(2, 32'h5555_5555, ncyc);
        chk("wr_cyc_len", 32'(ncyc), 32'd2);
        rsp_take(1'b0, 32'h0);

        // 3. read, ack in fourth bus cycle, response backpressured
        do_cmd(1'b0, 32'h3000_0004, 32'h0, 4'hF);
        bus_txn(4, 32'h0000_0005, ncyc);
        chk("rd_cyc_len", 32'(ncyc), 32'd4);
        for (int i = 0; i < 5; i++) begin
            sdat = 32'hFFFF_0000 + 32'(i);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_dat", rsp_dat, 32'h5);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        rsp_take(1'b0, 32'h5);

        // 4. timeout twice (counter must restart), then a normal minimum-latency read
        for (int k = 0; k < 2; k++) begin
            do_cmd(1'b0, 32'h3000_0008, 32'h0, 4'h3);
            bus_txn(0, 32'h0, ncyc);
            chk("to_cyc_len", 32'(ncyc), 32'd8);
            rsp_take(1'b1, 32'h0);
        end
        do_cmd(1'b0, 32'h3000_000C, 32'h0, 4'hF);
        bus_txn(1, 32'hDEAD_BEEF, ncyc);
        chk("min_cyc_len", 32'(ncyc), 32'd1);
        rsp_take(1'b0, 32'hDEAD_BEEF);

        // 5. ack on the timeout edge wins
        do_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        bus_txn(8, 32'h0000_1234, ncyc);
        chk("edge_cyc_len", 32'(ncyc), 32'd8);
        rsp_take(1'b0, 32'h0000_1234);

        // 6. reset in third bus cycle, then spurious ack while idle
        do_cmd(1'b0, 32'h3000_0014, 32'h0, 4'hF);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_cyc", 32'(cyc), 32'd0);
        chk("mrst_stb", 32'(stb), 32'd0);
        chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mrst_cmd_ready", 32'(cmd_ready), 32'd1);
        ack = 1'b1; sdat = 32'h7777_7777;
        @(negedge clk);
        ack = 1'b0;
        chk("spur_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("spur_cyc", 32'(cyc), 32'd0);
        chk("spur_cmd_ready", 32'(cmd_ready), 32'd1);
        do_cmd(1'b1, 32'h3000_0018, 32'h0000_0042, 4'h1);
        bus_txn(1, 32'h0, ncyc);
        chk("post_rst_len", 32'(ncyc), 32'd1);
        rsp_take(1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
